// File: rtl/coefficient_store_ctrl.sv
// Responder side of the FIR coefficient-load handshake: captures each word,
// holds modwait for WRITE_CYCLES while it commits, and tracks set ordering.
module coefficient_store_ctrl #(
    parameter int DATA_W       = 16,
    parameter int WRITE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              load_coeff,
    input  logic [1:0]        coefficient_num,
    input  logic [DATA_W-1:0] coeff_in,
    input  logic              sample_busy,
    output logic              modwait,
    output logic [DATA_W-1:0] f0_coeff,
    output logic [DATA_W-1:0] f1_coeff,
    output logic [DATA_W-1:0] f2_coeff,
    output logic [DATA_W-1:0] f3_coeff,
    output logic              coeff_set_valid,
    output logic              order_err,
    output logic              overrun_err
);

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WRITE_CYCLES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_busy;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [1:0]        r_idx;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_coeff [4];
    logic [1:0]        r_expected;
    logic              r_set_clean;
    logic              r_set_valid;
    logic              r_order_err;
    logic              r_overrun_err;

    logic              w_accept;
    logic              w_overrun;
    logic              w_commit;
    logic              w_in_order;

    assign modwait    = r_busy | sample_busy;
    assign w_accept   = load_coeff & ~modwait;
    assign w_overrun  = load_coeff & modwait;
    assign w_commit   = (r_state == S_WRITE) && (r_cnt == 4'd1);
    assign w_in_order = (coefficient_num == r_expected);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WRITE;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_WRITE: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_WRITE);
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: the slot registers feed the filter directly and must read zero
    // after reset, so they are reset like any other flop, not left as RAM.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_idx  <= 2'd0;
            r_data <= '0;
            for (int i = 0; i < 4; i++) begin
                r_coeff[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_idx  <= coefficient_num;
                r_data <= coeff_in;
            end
            if (w_commit) begin
                r_coeff[r_idx] <= r_data;
            end
        end
    end

    // Index 0 always opens a fresh set; any other out-of-sequence index
    // taints the set until a clean 0..3 run completes.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_expected    <= 2'd0;
            r_set_clean   <= 1'b0;
            r_set_valid   <= 1'b0;
            r_order_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_overrun) begin
                r_overrun_err <= 1'b1;
            end
            if (w_accept) begin
                r_expected <= coefficient_num + 2'd1;
                if (coefficient_num == 2'd0) begin
                    r_set_valid <= 1'b0;
                    r_set_clean <= 1'b1;
                end else if (!w_in_order) begin
                    r_order_err <= 1'b1;
                    r_set_clean <= 1'b0;
                end
            end
            if (w_commit && (r_idx == 2'd3) && r_set_clean) begin
                r_set_valid <= 1'b1;
                r_order_err <= 1'b0;
            end
        end
    end

    assign f0_coeff        = r_coeff[0];
    assign f1_coeff        = r_coeff[1];
    assign f2_coeff        = r_coeff[2];
    assign f3_coeff        = r_coeff[3];
    assign coeff_set_valid = r_set_valid;
    assign order_err       = r_order_err;
    assign overrun_err     = r_overrun_err;

endmodule

// File: tb/tb_coefficient_store_ctrl.sv
// Directed bench for coefficient_store_ctrl: a WRITE_CYCLES=2 instance for
// the handshake/ordering/overrun/reset steps, and a WRITE_CYCLES=1 instance.
module tb_coefficient_store_ctrl;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        load_coeff;
    logic [1:0]  coefficient_num;
    logic [15:0] coeff_in;
    logic        sample_busy;
    logic        modwait;
    logic [15:0] f0_coeff, f1_coeff, f2_coeff, f3_coeff;
    logic        coeff_set_valid, order_err, overrun_err;

    logic        b_load;
    logic [1:0]  b_num;
    logic [15:0] b_data;
    logic        b_sample_busy;
    logic        b_modwait;
    logic [15:0] b_f0, b_f1, b_f2, b_f3;
    logic        b_valid, b_order_err, b_overrun_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coefficient_store_ctrl #(.DATA_W(16), .WRITE_CYCLES(2)) dut (
        .clk(clk), .n_reset(n_reset), .load_coeff(load_coeff),
        .coefficient_num(coefficient_num), .coeff_in(coeff_in),
        .sample_busy(sample_busy), .modwait(modwait),
        .f0_coeff(f0_coeff), .f1_coeff(f1_coeff), .f2_coeff(f2_coeff), .f3_coeff(f3_coeff),
        .coeff_set_valid(coeff_set_valid), .order_err(order_err), .overrun_err(overrun_err)
    );

    coefficient_store_ctrl #(.DATA_W(16), .WRITE_CYCLES(1)) dut_b (
        .clk(clk), .n_reset(n_reset), .load_coeff(b_load),
        .coefficient_num(b_num), .coeff_in(b_data),
        .sample_busy(b_sample_busy), .modwait(b_modwait),
        .f0_coeff(b_f0), .f1_coeff(b_f1), .f2_coeff(b_f2), .f3_coeff(b_f3),
        .coeff_set_valid(b_valid), .order_err(b_order_err), .overrun_err(b_overrun_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] slot(input int i);
        case (i)
            0:       return f0_coeff;
            1:       return f1_coeff;
            2:       return f2_coeff;
            default: return f3_coeff;
        endcase
    endfunction

    // Presents one word for a single cycle; returns just after the accept edge.
    task automatic issue(input logic [1:0] idx, input logic [15:0] data);
        load_coeff      = 1'b1;
        coefficient_num = idx;
        coeff_in        = data;
        step();
        load_coeff      = 1'b0;
    endtask

    // Full word on the WRITE_CYCLES=2 instance with modwait and slot checks.
    task automatic do_word(input logic [1:0] idx, input logic [15:0] data, input string tag);
        check({tag, " ready"}, {31'd0, modwait}, 32'd0);
        issue(idx, data);
        check({tag, " modwait c1"}, {31'd0, modwait}, 32'd1);
        step();
        check({tag, " modwait c2"}, {31'd0, modwait}, 32'd1);
        step();
        check({tag, " modwait low"}, {31'd0, modwait}, 32'd0);
        check({tag, " slot"}, {16'd0, slot(int'(idx))}, {16'd0, data});
    endtask

    initial begin
        int stalls;
        int wait_cycles;
        n_reset         = 1'b0;
        load_coeff      = 1'b0;
        coefficient_num = 2'd0;
        coeff_in        = 16'd0;
        sample_busy     = 1'b0;
        b_load          = 1'b0;
        b_num           = 2'd0;
        b_data          = 16'd0;
        b_sample_busy   = 1'b0;
        step();
        step();

        // Reset state; modwait follows sample_busy even in reset
        check("rst f0", {16'd0, f0_coeff}, 32'd0);
        check("rst f3", {16'd0, f3_coeff}, 32'd0);
        check("rst valid", {31'd0, coeff_set_valid}, 32'd0);
        check("rst order_err", {31'd0, order_err}, 32'd0);
        check("rst overrun_err", {31'd0, overrun_err}, 32'd0);
        check("rst modwait", {31'd0, modwait}, 32'd0);
        sample_busy = 1'b1;
        #1;
        check("rst modwait=sample_busy", {31'd0, modwait}, 32'd1);
        sample_busy = 1'b0;
        n_reset     = 1'b1;
        step();

        // Step 1: clean set 0..3
        do_word(2'd0, 16'h1111, "t1 w0");
        do_word(2'd1, 16'h2222, "t1 w1");
        do_word(2'd2, 16'h3333, "t1 w2");
        issue(2'd3, 16'h4444);
        check("t1 w3 modwait c1", {31'd0, modwait}, 32'd1);
        step();
        check("t1 valid before commit", {31'd0, coeff_set_valid}, 32'd0);
        check("t1 f3 before commit", {16'd0, f3_coeff}, 32'd0);
        step();
        check("t1 valid at commit", {31'd0, coeff_set_valid}, 32'd1);
        check("t1 f3", {16'd0, f3_coeff}, 32'h4444);
        check("t1 modwait low", {31'd0, modwait}, 32'd0);
        check("t1 order_err", {31'd0, order_err}, 32'd0);
        check("t1 overrun_err", {31'd0, overrun_err}, 32'd0);

        // Step 2: new idx 0 clears valid at accept
        issue(2'd0, 16'hAAAA);
        check("t2 valid cleared", {31'd0, coeff_set_valid}, 32'd0);
        check("t2 f0 old", {16'd0, f0_coeff}, 32'h1111);
        step();
        step();
        check("t2 f0 new", {16'd0, f0_coeff}, 32'hAAAA);
        check("t2 f1", {16'd0, f1_coeff}, 32'h2222);
        check("t2 f2", {16'd0, f2_coeff}, 32'h3333);
        check("t2 f3", {16'd0, f3_coeff}, 32'h4444);

        // Step 3: order 0,2,1,3 then a clean set
        do_word(2'd0, 16'h5550, "t3 w0");
        check("t3 no err before idx2", {31'd0, order_err}, 32'd0);
        issue(2'd2, 16'h5552);
        check("t3 err at idx2 accept", {31'd0, order_err}, 32'd1);
        step();
        step();
        check("t3 f2", {16'd0, f2_coeff}, 32'h5552);
        do_word(2'd1, 16'h5551, "t3 w1");
        do_word(2'd3, 16'h5553, "t3 w3");
        check("t3 valid stays 0", {31'd0, coeff_set_valid}, 32'd0);
        check("t3 err sticky", {31'd0, order_err}, 32'd1);
        check("t3 f0", {16'd0, f0_coeff}, 32'h5550);
        do_word(2'd0, 16'h6660, "t3 c0");
        check("t3 err kept on idx0", {31'd0, order_err}, 32'd1);
        do_word(2'd1, 16'h6661, "t3 c1");
        do_word(2'd2, 16'h6662, "t3 c2");
        do_word(2'd3, 16'h6663, "t3 c3");
        check("t3 err cleared", {31'd0, order_err}, 32'd0);
        check("t3 valid set", {31'd0, coeff_set_valid}, 32'd1);

        // Step 4: overrun from busy_q, then from sample_busy
        issue(2'd0, 16'h7770);
        load_coeff      = 1'b1;
        coefficient_num = 2'd2;
        coeff_in        = 16'hDEAD;
        step();
        load_coeff = 1'b0;
        check("t4 overrun busy", {31'd0, overrun_err}, 32'd1);
        check("t4 modwait c2", {31'd0, modwait}, 32'd1);
        step();
        check("t4 modwait low", {31'd0, modwait}, 32'd0);
        check("t4 f0", {16'd0, f0_coeff}, 32'h7770);
        check("t4 f2 unchanged", {16'd0, f2_coeff}, 32'h6662);
        sample_busy = 1'b1;
        #1;
        check("t4 modwait sample_busy", {31'd0, modwait}, 32'd1);
        issue(2'd1, 16'hBAD1);
        sample_busy = 1'b0;
        #1;
        check("t4 request ignored", {31'd0, modwait}, 32'd0);
        step();
        step();
        check("t4 f1 unchanged", {16'd0, f1_coeff}, 32'h6661);
        check("t4 overrun sticky", {31'd0, overrun_err}, 32'd1);
        // sample_busy raised mid-commit does not stall the commit
        issue(2'd1, 16'h7771);
        sample_busy = 1'b1;
        step();
        step();
        check("t4 commit under sample_busy", {16'd0, f1_coeff}, 32'h7771);
        check("t4 modwait held by sample_busy", {31'd0, modwait}, 32'd1);
        sample_busy = 1'b0;
        #1;
        check("t4 modwait released", {31'd0, modwait}, 32'd0);

        // Step 5: reset mid-WRITE of idx 1
        issue(2'd1, 16'hBEEF);
        #1;
        n_reset = 1'b0;
        #1;
        check("t5 f1 reset", {16'd0, f1_coeff}, 32'd0);
        check("t5 modwait", {31'd0, modwait}, 32'd0);
        check("t5 overrun cleared", {31'd0, overrun_err}, 32'd0);
        check("t5 valid cleared", {31'd0, coeff_set_valid}, 32'd0);
        step();
        n_reset = 1'b1;
        step();
        step();
        check("t5 f1 stays 0", {16'd0, f1_coeff}, 32'd0);
        do_word(2'd0, 16'h1234, "t5 w0");
        check("t5 no order_err", {31'd0, order_err}, 32'd0);

        // Step 6: WRITE_CYCLES=1 instance driven back-to-back by a loader model
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            wait_cycles = 0;
            while (b_modwait && wait_cycles < 20) begin
                step();
                wait_cycles++;
            end
            check("t6 wait bound", {31'd0, b_modwait}, 32'd0);
            stalls += wait_cycles;
            b_load = 1'b1;
            b_num  = 2'(i);
            b_data = 16'hC0D0 + 16'(i);
            step();
            b_load = 1'b0;
            check("t6 modwait high 1", {31'd0, b_modwait}, 32'd1);
            step();
            check("t6 modwait low 2", {31'd0, b_modwait}, 32'd0);
        end
        check("t6 no stalls", stalls, 32'd0);
        check("t6 f0", {16'd0, b_f0}, 32'hC0D0);
        check("t6 f1", {16'd0, b_f1}, 32'hC0D1);
        check("t6 f2", {16'd0, b_f2}, 32'hC0D2);
        check("t6 f3", {16'd0, b_f3}, 32'hC0D3);
        check("t6 valid", {31'd0, b_valid}, 32'd1);
        check("t6 overrun", {31'd0, b_overrun_err}, 32'd0);
        check("t6 order_err", {31'd0, b_order_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coefficient_store_ctrl.md
Name: coefficient_store_ctrl

Overview:
Responder side of the coefficient-load handshake (load_coeff / coefficient_num / modwait) used by the FIR filter.
- Captures each coefficient word the loader presents.
- Holds modwait high while the word is committed to its slot (F0..F3).
- Tracks load order and reports when a complete, in-order set of four coefficients is resident.
- Sits between the coefficient loader FSM and the FIR datapath coefficient registers.

Parameters:
DATA_W, 16, coefficient word width.
WRITE_CYCLES, 2, busy cycles per committed word (legal range 1..15).

Ports:
clk  input  1  system clock.
n_reset  input  1  asynchronous, active-low reset.
load_coeff  input  1  loader request; a 1-cycle pulse per word.
coefficient_num  input  2  slot index of the presented word.
coeff_in  input  DATA_W  coefficient value, valid with load_coeff.
sample_busy  input  1  datapath busy with a sample; merged into modwait.
modwait  output  1  busy indication back to the loader.
f0_coeff, f1_coeff, f2_coeff, f3_coeff  output  DATA_W each  stored coefficients.
coeff_set_valid  output  1  high while a complete in-order set is stored.
order_err  output  1  sticky out-of-order-index flag.
overrun_err  output  1  sticky load-while-busy flag.

Behaviour:
Reset is asynchronous on n_reset low. Reset values:
- State IDLE, busy counter 0, expected index 0.
- f0..f3 = 0.
- coeff_set_valid = 0, order_err = 0, overrun_err = 0.
- modwait = sample_busy (combinational OR, defined below).

modwait = busy_q OR sample_busy. busy_q is a register.

FSM states:
- IDLE: busy_q = 0.
  - Accept condition: load_coeff = 1 AND modwait = 0 in the same cycle.
  - On accept at edge E: latch coefficient_num → idx_q and coeff_in → data_q, load the counter with WRITE_CYCLES, set busy_q = 1, go to WRITE.
  - Result: modwait is high in the cycle right after the load_coeff cycle. This is mandatory, because the loader samples modwait in its wait state one cycle after LOADn.
- WRITE: busy_q = 1; the counter decrements every cycle.
  - When the counter reaches 1: commit data_q into slot idx_q on that edge, clear busy_q, return to IDLE.
  - Total modwait-high time from busy_q is exactly WRITE_CYCLES cycles.
  - The slot output updates on the same edge at which busy_q falls.

Order tracking (evaluated at accept):
- idx = 0: clears coeff_set_valid and starts a new set.
  - order_err is NOT cleared on a bare index-0 load.
  - order_err clears only when that set then completes in order (commit of index 3 with no error during the set).
- idx ≠ expected: set order_err. The word is still committed. Expected becomes idx+1, modulo 4.
- idx = 3 commit with the set error-free since its index 0: set coeff_set_valid.
- An error inside a set keeps coeff_set_valid = 0 until a clean 0,1,2,3 sequence completes.

overrun_err:
- Set when load_coeff = 1 while modwait = 1, whether the cause is busy_q or sample_busy.
- The request is ignored: no capture, and state, counter and slots are unchanged.
- Sticky; cleared only by reset.

Other rules:
- sample_busy does not affect the counter. A commit in progress completes even if sample_busy is high.
- Slot outputs hold their value between commits. Committing a slot changes no other slot.
- An n_reset assertion mid-WRITE aborts the commit; all outputs return to reset values.
- Data is exactly DATA_W bits; no arithmetic on it.

Test Plan:
1. Reset, then loads idx 0..3 with values 0x1111, 0x2222, 0x3333, 0x4444, each issued when modwait = 0 (WRITE_CYCLES = 2) → modwait high 2 cycles after each load; f0..f3 = 0x1111..0x4444; coeff_set_valid rises on the edge committing f3; no errors.
2. After a valid set, load idx 0 value 0xAAAA → coeff_set_valid falls at the accept edge; f0 becomes 0xAAAA 2 cycles later; f1..f3 unchanged.
3. Load sequence 0, 2, 1, 3 → order_err set at the idx-2 accept; all four slots written; coeff_set_valid stays 0; a following clean 0..3 set clears order_err and sets coeff_set_valid.
4. load_coeff pulse one cycle after an accept (busy_q = 1), and a second pulse while sample_busy = 1 in IDLE → overrun_err = 1; slots unchanged; modwait timing of the original commit unaffected.
5. Reset asserted in the middle of a WRITE of idx 1 value 0xBEEF → f1 stays 0; modwait = 0 once sample_busy = 0; counters reset; next load accepted normally.
6. WRITE_CYCLES = 1 build with back-to-back loads driven by a loader model → modwait high exactly 1 cycle per word; the loader never stalls incorrectly; final f0..f3 match the stimulus.
